// File: rtl/instruction_fetch_responder.sv
// Instruction-fetch responder: one request in flight, ROM lookup, response LATENCY edges after accept.
// The ROM image is a packed parameter (word i at bits [32*i +: 32]); words not given are zero.
module instruction_fetch_responder #(
  parameter int unsigned DEPTH_WORDS = 128,
  parameter int unsigned LATENCY     = 2,
  parameter logic [DEPTH_WORDS*32-1:0] ROM_INIT = '0
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic [31:0] ReqAddress,
  output logic        RespValid,
  input  logic        RespReady,
  output logic [31:0] RespInstruction,
  output logic [31:0] RespAddress,
  output logic        AddrError
);

  // state  | meaning
  // S_IDLE | ready for a request
  // S_WAIT | request latched, counting down to the response
  // S_RESP | response presented until the consumer takes it
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);
  localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH_WORDS);

  state_t          state;
  state_t          state_nxt;
  logic [3:0]      cnt;
  logic [31:0]     addr_q;
  logic            accept;
  logic            load_resp;
  logic            load_err;
  logic [AW-1:0]   load_idx;
  logic [31:0]     rom_word;

  assign accept    = ReqValid & ReqReady;
  assign load_resp = (state == S_WAIT) && (cnt == 4'd0);
  assign load_idx  = addr_q[AW+1:2];
  assign load_err  = (addr_q[1:0] != 2'b00) || (addr_q >= ADDR_LIMIT);
  assign rom_word  = ROM_INIT[32*load_idx +: 32];

  always_ff @(posedge Clk) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_WAIT;
      S_WAIT:  if (cnt == 4'd0) state_nxt = S_RESP;
      S_RESP:  if (RespReady) state_nxt = accept ? S_WAIT : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // In RESP a new request is only taken while the current response retires.
  always_comb begin
    ReqReady  = 1'b0;
    RespValid = (state == S_RESP);
    if (!Reset) begin
      if (state == S_IDLE)      ReqReady = 1'b1;
      else if (state == S_RESP) ReqReady = RespReady;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt             <= 4'd0;
      addr_q          <= 32'd0;
      RespInstruction <= 32'd0;
      RespAddress     <= 32'd0;
      AddrError       <= 1'b0;
    end else begin
      if (accept) begin
        addr_q <= ReqAddress;
        cnt    <= LAT_M1;
      end else if (state == S_WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (load_resp) begin
        RespAddress     <= addr_q;
        AddrError       <= load_err;
        RespInstruction <= load_err ? 32'd0 : rom_word;
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch_responder.sv
// Bench for instruction_fetch_responder: a LATENCY=2 instance (table, corner sequences, random)
// and a LATENCY=1 instance (full address sweep), both checked against a ROM-image model.
module tb_instruction_fetch_responder;

  localparam int DEPTH = 128;

  function automatic logic [31:0] img_word(int i);
    if (i == 0) return 32'h2008_0005;
    return {8'(i * 37 + 11), 8'h13, 8'(i), 8'hC3};
  endfunction

  function automatic logic [DEPTH*32-1:0] gen_rom();
    logic [DEPTH*32-1:0] r;
    r = '0;
    for (int i = 0; i < DEPTH; i++) r[i*32 +: 32] = img_word(i);
    return r;
  endfunction

  localparam logic [DEPTH*32-1:0] ROM_IMG = gen_rom();

  function automatic logic exp_err(logic [31:0] a);
    return (a[1:0] != 2'b00) || (a >= 32'(4 * DEPTH));
  endfunction

  function automatic logic [31:0] exp_instr(logic [31:0] a);
    if (exp_err(a)) return 32'd0;
    return img_word(int'(a >> 2));
  endfunction

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, resp_valid, resp_ready, addr_error;
  logic [31:0] req_address, resp_instruction, resp_address;
  logic        req_valid_1, req_ready_1, resp_valid_1, resp_ready_1, addr_error_1;
  logic [31:0] req_address_1, resp_instruction_1, resp_address_1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  instruction_fetch_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2), .ROM_INIT(ROM_IMG)) u_dut (
    .Clk(clk), .Reset(reset),
    .ReqValid(req_valid), .ReqReady(req_ready), .ReqAddress(req_address),
    .RespValid(resp_valid), .RespReady(resp_ready),
    .RespInstruction(resp_instruction), .RespAddress(resp_address), .AddrError(addr_error)
  );

  instruction_fetch_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1), .ROM_INIT(ROM_IMG)) u_dut_1 (
    .Clk(clk), .Reset(reset),
    .ReqValid(req_valid_1), .ReqReady(req_ready_1), .ReqAddress(req_address_1),
    .RespValid(resp_valid_1), .RespReady(resp_ready_1),
    .RespInstruction(resp_instruction_1), .RespAddress(resp_address_1), .AddrError(addr_error_1)
  );

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_req(logic [31:0] a);
    req_valid   = 1'b1;
    req_address = a;
    #1;
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    step();
    req_valid   = 1'b0;
    req_address = $urandom;
  endtask

  task automatic wait_resp(string name);
    int lat;
    lat = 0;
    while (!resp_valid && lat < 20) begin
      step();
      lat++;
    end
    chk(name, lat, 2);
  endtask

  task automatic check_resp(string name, logic [31:0] a);
    chk({name, "_valid"}, 32'(resp_valid), 32'd1);
    chk({name, "_instr"}, resp_instruction, exp_instr(a));
    chk({name, "_addr"}, resp_address, a);
    chk({name, "_err"}, 32'(addr_error), 32'(exp_err(a)));
  endtask

  task automatic retire();
    resp_ready = 1'b1;
    #1;
    chk("retire_ready", 32'(req_ready), 32'd1);
    step();
    resp_ready = 1'b0;
    chk("retire_valid", 32'(resp_valid), 32'd0);
    chk("idle_ready", 32'(req_ready), 32'd1);
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 3))
      0, 1:    return 32'($urandom_range(0, DEPTH - 1)) << 2;
      2:       return 32'($urandom_range(0, 4 * DEPTH - 1)) | 32'd1;
      default: return 32'(4 * DEPTH) + (32'($urandom_range(0, 255)) << 2);
    endcase
  endfunction

  typedef struct {
    logic [31:0] addr;
    logic        err;
    logic [31:0] instr;
    int          hold;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [31:0] a;
    logic        pending;

    vecs[0] = '{32'h0000_0000, 1'b0, 32'h2008_0005, 5};
    vecs[1] = '{32'h0000_0004, 1'b0, img_word(1),   0};
    vecs[2] = '{32'h0000_0002, 1'b1, 32'h0,         1};
    vecs[3] = '{32'h0000_0200, 1'b1, 32'h0,         0};
    vecs[4] = '{32'h0000_01FC, 1'b0, img_word(127), 2};
    vecs[5] = '{32'h0000_01FE, 1'b1, 32'h0,         0};
    vecs[6] = '{32'hFFFF_FFFC, 1'b1, 32'h0,         0};
    vecs[7] = '{32'h0000_0154, 1'b0, img_word(85),  3};

    reset = 1'b1;
    req_valid = 1'b0; req_address = 32'd0; resp_ready = 1'b0;
    req_valid_1 = 1'b0; req_address_1 = 32'd0; resp_ready_1 = 1'b0;
    step();
    step();
    chk("rst_ready_low", 32'(req_ready), 32'd0);
    chk("rst_valid", 32'(resp_valid), 32'd0);
    chk("rst_instr", resp_instruction, 32'd0);
    chk("rst_addr", resp_address, 32'd0);
    chk("rst_err", 32'(addr_error), 32'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_ready", 32'(req_ready), 32'd1);

    for (int i = 0; i < 8; i++) begin
      start_req(vecs[i].addr);
      wait_resp("tbl_latency");
      chk("tbl_instr", resp_instruction, vecs[i].instr);
      chk("tbl_addr", resp_address, vecs[i].addr);
      chk("tbl_err", 32'(addr_error), 32'(vecs[i].err));
      for (int k = 0; k < vecs[i].hold; k++) begin
        step();
        chk("hold_valid", 32'(resp_valid), 32'd1);
        chk("hold_instr", resp_instruction, vecs[i].instr);
        chk("hold_ready", 32'(req_ready), 32'd0);
      end
      retire();
    end

    // back-to-back: new request accepted while the old response retires
    start_req(32'd0);
    wait_resp("b2b_first_lat");
    resp_ready = 1'b1; req_valid = 1'b1; req_address = 32'd4;
    #1;
    chk("b2b_ready", 32'(req_ready), 32'd1);
    step();
    resp_ready = 1'b0; req_valid = 1'b0; req_address = 32'hDEAD_BEEF;
    chk("b2b_no_idle", 32'(req_ready), 32'd0);
    chk("b2b_gap_valid", 32'(resp_valid), 32'd0);
    chk("b2b_old_addr_held", resp_address, 32'd0);
    wait_resp("b2b_lat");
    check_resp("b2b", 32'd4);
    retire();

    // reset while waiting drops the request
    start_req(32'd8);
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("rstwait_valid", 32'(resp_valid), 32'd0);
    end
    chk("rstwait_ready", 32'(req_ready), 32'd1);
    chk("rstwait_instr", resp_instruction, 32'd0);
    chk("rstwait_addr", resp_address, 32'd0);
    chk("rstwait_err", 32'(addr_error), 32'd0);

    // random traffic mixing idle starts, back-to-back and stalls
    pending = 1'b0;
    for (int t = 0; t < 60; t++) begin
      a = rand_addr();
      if (pending && $urandom_range(0, 1) == 1) begin
        for (int k = $urandom_range(0, 2); k > 0; k--) begin
          step();
          chk("rnd_hold_valid", 32'(resp_valid), 32'd1);
        end
        resp_ready = 1'b1; req_valid = 1'b1; req_address = a;
        step();
        resp_ready = 1'b0; req_valid = 1'b0; req_address = $urandom;
      end else begin
        if (pending) retire();
        start_req(a);
      end
      wait_resp("rnd_lat");
      check_resp("rnd", a);
      pending = 1'b1;
    end
    retire();

    // LATENCY=1 instance: chained sweep over the whole ROM
    req_valid_1 = 1'b1; req_address_1 = 32'd0;
    #1;
    chk("l1_ready", 32'(req_ready_1), 32'd1);
    step();
    for (int i = 0; i < DEPTH; i++) begin
      a = 32'(i) << 2;
      req_valid_1 = 1'b0; resp_ready_1 = 1'b0; req_address_1 = $urandom;
      chk("l1_wait_valid", 32'(resp_valid_1), 32'd0);
      step();
      chk("l1_valid", 32'(resp_valid_1), 32'd1);
      chk("l1_instr", resp_instruction_1, exp_instr(a));
      chk("l1_addr", resp_address_1, a);
      chk("l1_err", 32'(addr_error_1), 32'd0);
      resp_ready_1 = 1'b1;
      if (i < DEPTH - 1) begin
        req_valid_1 = 1'b1; req_address_1 = a + 32'd4;
      end
      step();
    end
    resp_ready_1 = 1'b0; req_valid_1 = 1'b0;
    chk("l1_end_valid", 32'(resp_valid_1), 32'd0);
    chk("l1_end_ready", 32'(req_ready_1), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
